// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences one scan test on an external chain.
// Optional preset, serial shift-in of a stimulus pattern, optional capture
// cycle, serial shift-out into a response register, then compare with the
// expected response. Every output comes straight from a register.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 16,
    parameter int PRESET_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 PRESET_EN,
    input  logic                 CAPTURE_EN,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic                 SO,
    output logic                 SCE,
    output logic                 SCD,
    output logic                 SETB,
    output logic                 CHAIN_CLK_EN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [CHAIN_LEN-1:0] RESP_OUT
);

    // The counter is sized for the shift length; it only grows if the
    // preset length alone would not fit, so it never wraps.
    localparam int CNT_W_LEN = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W_PRE = $clog2(PRESET_CYC + 1);
    localparam int CNT_W     = (CNT_W_LEN > CNT_W_PRE) ? CNT_W_LEN : CNT_W_PRE;

    // Down-counter reload values: a phase lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] LEN_LOAD = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRESET_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESET    = 3'd1,
        ST_SHIFT_IN  = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_SHIFT_OUT = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CHAIN_LEN-1:0]   pat_r;     // remaining stimulus bits, LSB next
    logic [CHAIN_LEN-1:0]   exp_r;
    logic                   cap_en_r;
    logic                   sce_r;
    logic                   scd_r;
    logic                   setb_r;
    logic                   clk_en_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   pass_r;
    logic [CHAIN_LEN-1:0]   resp_r;

    // Sequencer: state, phase counter, chain controls and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            pat_r    <= '0;
            exp_r    <= '0;
            cap_en_r <= 1'b0;
            sce_r    <= 1'b0;
            scd_r    <= 1'b0;
            setb_r   <= 1'b1;
            clk_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            resp_r   <= '0;
        end else if ((state_r != ST_IDLE) && ABORT) begin
            // Abort drops the sequence silently; the response register is
            // left as-is, but PASS is forced low so no stale verdict remains.
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            sce_r    <= 1'b0;
            scd_r    <= 1'b0;
            setb_r   <= 1'b1;
            clk_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // ABORT in the same cycle suppresses the start.
                    if (START && !ABORT) begin
                        exp_r    <= EXP_IN;
                        cap_en_r <= CAPTURE_EN;
                        pass_r   <= 1'b0;
                        resp_r   <= '0;
                        busy_r   <= 1'b1;
                        if (PRESET_EN) begin
                            state_r  <= ST_PRESET;
                            cnt_r    <= PRE_LOAD;
                            pat_r    <= PAT_IN;
                            setb_r   <= 1'b0;
                            sce_r    <= 1'b0;
                            scd_r    <= 1'b0;
                            clk_en_r <= 1'b0;
                        end else begin
                            state_r  <= ST_SHIFT_IN;
                            cnt_r    <= LEN_LOAD;
                            pat_r    <= PAT_IN >> 1;
                            scd_r    <= PAT_IN[0];
                            setb_r   <= 1'b1;
                            sce_r    <= 1'b1;
                            clk_en_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_PRESET: begin
                    if (cnt_r == '0) begin
                        state_r  <= ST_SHIFT_IN;
                        cnt_r    <= LEN_LOAD;
                        setb_r   <= 1'b1;
                        sce_r    <= 1'b1;
                        clk_en_r <= 1'b1;
                        scd_r    <= pat_r[0];
                        pat_r    <= pat_r >> 1;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end

                ST_SHIFT_IN: begin
                    if (cnt_r == '0) begin
                        scd_r    <= 1'b0;
                        clk_en_r <= 1'b1;
                        if (cap_en_r) begin
                            state_r <= ST_CAPTURE;
                            cnt_r   <= '0;
                            sce_r   <= 1'b0;
                        end else begin
                            state_r <= ST_SHIFT_OUT;
                            cnt_r   <= LEN_LOAD;
                            sce_r   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                        scd_r <= pat_r[0];
                        pat_r <= pat_r >> 1;
                    end
                end

                ST_CAPTURE: begin
                    state_r  <= ST_SHIFT_OUT;
                    cnt_r    <= LEN_LOAD;
                    sce_r    <= 1'b1;
                    scd_r    <= 1'b0;
                    clk_en_r <= 1'b1;
                end

                ST_SHIFT_OUT: begin
                    // First bit out travels down to bit 0 after CHAIN_LEN shifts.
                    resp_r <= {SO, resp_r[CHAIN_LEN-1:1]};
                    if (cnt_r == '0) begin
                        state_r  <= ST_FINISH;
                        cnt_r    <= '0;
                        sce_r    <= 1'b0;
                        clk_en_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end

                ST_FINISH: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    pass_r  <= (resp_r == exp_r);
                end

                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= '0;
                    sce_r    <= 1'b0;
                    scd_r    <= 1'b0;
                    setb_r   <= 1'b1;
                    clk_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    pass_r   <= 1'b0;
                end
            endcase
        end
    end

    assign SCE          = sce_r;
    assign SCD          = scd_r;
    assign SETB         = setb_r;
    assign CHAIN_CLK_EN = clk_en_r;
    assign BUSY         = busy_r;
    assign DONE         = done_r;
    assign PASS         = pass_r;
    assign RESP_OUT     = resp_r;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl with a 4-flop chain
// model looped back to SO (functional D input tied to 0).
module tb_scan_chain_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       PRESET_EN = 1'b0;
    logic       CAPTURE_EN = 1'b0;
    logic [3:0] PAT_IN = 4'b0000;
    logic [3:0] EXP_IN = 4'b0000;
    logic       SO;
    logic       SCE, SCD, SETB, CHAIN_CLK_EN, BUSY, DONE, PASS;
    logic [3:0] RESP_OUT;

    logic [3:0] chain = 4'b0000;

    int n_cmp = 0;
    int n_err = 0;

    scan_chain_ctrl #(.CHAIN_LEN(4), .PRESET_CYC(2)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .PRESET_EN(PRESET_EN), .CAPTURE_EN(CAPTURE_EN),
        .PAT_IN(PAT_IN), .EXP_IN(EXP_IN), .SO(SO),
        .SCE(SCE), .SCD(SCD), .SETB(SETB), .CHAIN_CLK_EN(CHAIN_CLK_EN),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .RESP_OUT(RESP_OUT)
    );

    always #5 CLK = ~CLK;

    // Chain model: set when SETB low, shift when scan enabled, capture D=0 otherwise.
    always @(posedge CLK) begin
        if (!SETB)
            chain <= 4'b1111;
        else if (CHAIN_CLK_EN)
            chain <= SCE ? {chain[2:0], SCD} : 4'b0000;
    end
    assign SO = chain[3];

    typedef struct {
        logic       pre;
        logic       cap;
        logic [3:0] pat;
        logic [3:0] expv;
        logic [3:0] resp;
        logic       pass;
        int         done_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic pass_req);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_setb"}, {31'd0, SETB}, 32'd1);
        chk({tag, "_sce"},  {31'd0, SCE}, 32'd0);
        chk({tag, "_clken"}, {31'd0, CHAIN_CLK_EN}, 32'd0);
        chk({tag, "_pass"}, {31'd0, PASS}, {31'd0, pass_req});
    endtask

    // Watch a window of cycles and count DONE pulses.
    task automatic count_done(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (DONE) dones++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, setb_low, cap_cyc, s;
        logic [3:0] scd_seen;
        logic got_done;
        @(negedge CLK);
        PRESET_EN = v.pre; CAPTURE_EN = v.cap; PAT_IN = v.pat; EXP_IN = v.expv;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk($sformatf("v%0d_busy", idx), {31'd0, BUSY}, 32'd1);
        s = v.pre ? 2 : 0;
        cyc = 0; setb_low = 0; cap_cyc = 0; scd_seen = 4'b0000; got_done = 1'b0;
        while (cyc < 40) begin
            if (!SETB) setb_low++;
            if (!SCE && CHAIN_CLK_EN) cap_cyc++;
            if (cyc >= s && cyc < s + 4) scd_seen[cyc-s] = SCD;
            if (DONE) begin
                got_done = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        chk($sformatf("v%0d_done_seen", idx), {31'd0, got_done}, 32'd1);
        chk($sformatf("v%0d_done_cycle", idx), cyc, v.done_cyc);
        chk($sformatf("v%0d_pass", idx), {31'd0, PASS}, {31'd0, v.pass});
        chk($sformatf("v%0d_resp", idx), {28'd0, RESP_OUT}, {28'd0, v.resp});
        chk($sformatf("v%0d_scd_seq", idx), {28'd0, scd_seen}, {28'd0, v.pat});
        chk($sformatf("v%0d_setb_low", idx), setb_low, v.pre ? 2 : 0);
        chk($sformatf("v%0d_capture", idx), cap_cyc, v.cap ? 1 : 0);
        tick();
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, DONE}, 32'd0);
        chk($sformatf("v%0d_pass_hold", idx), {31'd0, PASS}, {31'd0, v.pass});
        chk($sformatf("v%0d_resp_hold", idx), {28'd0, RESP_OUT}, {28'd0, v.resp});
    endtask

    initial begin
        int dones, done_at;
        vecs[0] = '{1'b0, 1'b0, 4'b1011, 4'b1011, 4'b1011, 1'b1, 9};
        vecs[1] = '{1'b0, 1'b0, 4'b1011, 4'b1010, 4'b1011, 1'b0, 9};
        vecs[2] = '{1'b1, 1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 12};
        vecs[3] = '{1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0110, 1'b1, 11};
        vecs[4] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 10};
        vecs[5] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 9};

        // Reset state
        tick(); tick();
        chk_idle_outputs("reset", 1'b0);
        chk("reset_scd", {31'd0, SCD}, 32'd0);
        chk("reset_resp", {28'd0, RESP_OUT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // START pulsed at cycle 3 of a running sequence is ignored
        @(negedge CLK);
        PRESET_EN = 1'b0; CAPTURE_EN = 1'b0; PAT_IN = 4'b1011; EXP_IN = 4'b1011;
        START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0; done_at = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) START = 1'b1;
            if (c == 4) START = 1'b0;
            tick();
            if (DONE) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
        end
        chk("busy_start_done_count", dones, 1);
        chk("busy_start_done_cycle", done_at, 9);

        // ABORT during the second SHIFT_OUT cycle (after edge 5)
        @(negedge CLK);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk_idle_outputs("abort", 1'b0);
        count_done(15, dones);
        chk("abort_no_done", dones, 0);
        chk("abort_busy_stays_low", {31'd0, BUSY}, 32'd0);

        // ABORT and START together in IDLE: nothing starts
        @(negedge CLK);
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("idle_abort_start_busy", {31'd0, BUSY}, 32'd0);
        count_done(15, dones);
        chk("idle_abort_start_no_done", dones, 0);

        // RESET together with START during SHIFT_IN
        run_vec(6, vecs[0]);
        @(negedge CLK);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RESET = 1'b1; START = 1'b1;
        tick();
        chk_idle_outputs("midreset", 1'b0);
        chk("midreset_scd", {31'd0, SCD}, 32'd0);
        chk("midreset_resp", {28'd0, RESP_OUT}, 32'd0);
        RESET = 1'b0; START = 1'b0;
        count_done(15, dones);
        chk("midreset_no_done", dones, 0);
        chk("midreset_idle_busy", {31'd0, BUSY}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
